sine_req_arbiter: RTL and testbench
===================================

Name: sine_req_arbiter

Overview:
- Shares one iterative CORDIC sine engine between NUM_REQ requesters using round-robin arbitration.
- Captures the winner's angle, pulses the engine start, waits for the engine's done, then returns the sine result tagged to the winner.
- Sits between the per-channel angle sources and the single sine engine instance. Only the arbiter drives the engine's start and angle inputs.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- DATA_W, 16: angle and result width.
- TIMEOUT_CYCLES, 64: maximum cycles waited for engine done. Used only with SINE_ARB_TIMEOUT_EN.

Ports:
- Clk_i  in  1  system clock.
- Rst_ni  in  1  reset; synchronous, active-low. The top level feeds the engine's active-high reset from the inverse of this signal.
- Req_i  in  NUM_REQ  per-requester request level. Held high until Ack.
- Angle_i  in  NUM_REQ*DATA_W  packed angles; requester k occupies bits [k*DATA_W +: DATA_W].
- Ack_o  out  NUM_REQ  one-hot, one-cycle pulse; the angle has been captured.
- Valid_o  out  NUM_REQ  one-hot, one-cycle pulse; Result_o belongs to that requester.
- Result_o  out  DATA_W  last returned sine; held until the next response.
- Err_o  out  1  qualifies Valid_o; 1 = engine timeout.
- Busy_o  out  1  high in every state except IDLE.
- Eng_Start_o  out  1  engine start strobe.
- Eng_Angle_o  out  DATA_W  registered angle sent to the engine.
- Eng_Done_i  in  1  engine done. This is a level: it stays high until the next start is accepted.
- Eng_Sine_i  in  DATA_W  engine result; valid while Eng_Done_i is high.

Behaviour:
- Reset (Rst_ni=0 at a clock edge) sets:
  - Ack_o, Valid_o, Result_o, Err_o, Busy_o, Eng_Start_o, Eng_Angle_o to 0.
  - Round-robin pointer to NUM_REQ-1, so requester 0 wins first.
  - State to IDLE.
- Reset mid-operation discards the pending job. No Valid_o is issued for it.
- FSM states: IDLE, START, CLEAR, BUSY, RESP.
- IDLE:
  - If any Req_i is set, select the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Register the selected angle into Eng_Angle_o and the index into the grant register.
  - Pulse Ack_o[grant] and Eng_Start_o for exactly one cycle, which is the START cycle.
  - Move the pointer to grant.
- START: lasts one cycle, then go to CLEAR.
- CLEAR:
  - Wait for Eng_Done_i=0. This is the engine acknowledging the start and dropping its stale done.
  - Then go to BUSY.
  - A done left high from the previous job is never taken as completion.
- BUSY:
  - On Eng_Done_i=1, capture Eng_Sine_i into Result_o and go to RESP.
- RESP:
  - Valid_o[grant]=1 for one cycle, then return to IDLE.
  - Requests are not sampled in RESP.
- Minimum gap between successive grants is 3 cycles plus the engine latency. The nominal engine latency is 17 cycles.
- Requester obligations:
  - Drop Req_i on the cycle after Ack.
  - A Req_i still high after Ack is treated as a new request. It competes fairly, so no requester starves.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority.
- Requests and angles of non-granted requesters are ignored until they win.
- Eng_Angle_o is held stable from START until the next grant.

Optional Feature:
- Macro: SINE_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in CLEAR and BUSY, cleared at START.
  - When it reaches TIMEOUT_CYCLES, go to RESP with Result_o=0 and Err_o=1 alongside Valid_o[grant].
  - Err_o returns to 0 on the next response.
  - The pointer advances normally.
- When undefined:
  - No counter exists; the arbiter waits indefinitely.
  - Err_o is tied to 0.

Test Plan:
Bench uses a behavioural engine model: done drops 1 cycle after start, rises 17 cycles after start, and result = angle XOR 16'hA5A5.
1. Single request, requester 2, angle 16'h1000:
   - Ack_o=4'b0100 one cycle after Req; Eng_Angle_o=16'h1000.
   - Valid_o=4'b0100 with Result_o=16'hB5A5, Err_o=0.
2. All four requesters assert together after reset, angles 16'h0001..16'h0004:
   - Acks in order 0,1,2,3.
   - Results 16'hA5A4, 16'hA5A7, 16'hA5A6, 16'hA5A1 in that order.
3. Fairness: Req_i[0] and Req_i[3] held high continuously for 6 grants → grant sequence 0,3,0,3,0,3.
4. Stale done: model holds Eng_Done_i=1 before START, angle 16'h00FF:
   - Arbiter stays in CLEAR until done drops.
   - Valid_o appears only after the new done, with Result_o=16'hA55A.
5. Reset during BUSY (Rst_ni=0 for 1 cycle):
   - All outputs 0 and no Valid_o for the aborted job.
   - Next request from requester 0 is granted first.
6. With SINE_ARB_TIMEOUT_EN, model never raises done:
   - Valid_o[grant]=1 with Err_o=1 and Result_o=0 exactly 64 cycles after CLEAR is entered.
   - Next request is served normally.

Source files
------------

// File: rtl/sine_req_arbiter.sv
// sine_req_arbiter
//   Round-robin arbiter sharing one iterative CORDIC sine engine between
//   NUM_REQ requesters. The winner's angle is registered and sent to the
//   engine with a one-cycle start strobe. The arbiter waits for the engine
//   to drop its stale done and then raise it again. The sine is returned
//   tagged to the winner with a one-cycle Valid_o pulse.
//
//   Optional feature: define SINE_ARB_TIMEOUT_EN to bound the wait for done
//   to TIMEOUT_CYCLES. An expired wait returns Result_o=0 with Err_o=1.
//   Without the macro the arbiter waits indefinitely and Err_o is tied low.
//
// Ports
//   Clk_i        system clock
//   Rst_ni       synchronous active-low reset
//   Req_i        per-requester request level, held until Ack_o
//   Angle_i      packed angles, requester k at [k*DATA_W +: DATA_W]
//   Ack_o        one-hot pulse: angle captured (START cycle)
//   Valid_o      one-hot pulse: Result_o belongs to that requester
//   Result_o     last returned sine, held until next response
//   Err_o        qualifies Valid_o, 1 = engine timeout
//   Busy_o       high in every state except IDLE
//   Eng_Start_o  engine start strobe
//   Eng_Angle_o  registered angle to the engine
//   Eng_Done_i   engine done level (high until next start accepted)
//   Eng_Sine_i   engine result, valid while Eng_Done_i is high
module sine_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      Clk_i,
  input  logic                      Rst_ni,
  input  logic [NUM_REQ-1:0]        Req_i,
  input  logic [NUM_REQ*DATA_W-1:0] Angle_i,
  output logic [NUM_REQ-1:0]        Ack_o,
  output logic [NUM_REQ-1:0]        Valid_o,
  output logic [DATA_W-1:0]         Result_o,
  output logic                      Err_o,
  output logic                      Busy_o,
  output logic                      Eng_Start_o,
  output logic [DATA_W-1:0]         Eng_Angle_o,
  input  logic                      Eng_Done_i,
  input  logic [DATA_W-1:0]         Eng_Sine_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sine_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CLEAR,
    S_BUSY,
    S_RESP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   sel_idx;
  logic [DATA_W-1:0]  sel_angle;
  logic               sel_found;
  logic [NUM_REQ-1:0] grant_oh;

  assign grant_oh = ONE_HOT0 << grant;

  // Round-robin search: first set request starting just above the pointer,
  // wrapping modulo NUM_REQ, so the last winner has lowest priority.
  always_comb begin
    int unsigned cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_angle = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!sel_found && Req_i[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
        sel_angle = Angle_i[cand*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SINE_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign Err_o = 1'b0;
`endif

  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      grant       <= '0;
      Ack_o       <= '0;
      Valid_o     <= '0;
      Result_o    <= '0;
      Busy_o      <= 1'b0;
      Eng_Start_o <= 1'b0;
      Eng_Angle_o <= '0;
`ifdef SINE_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      Err_o       <= 1'b0;
`endif
    end else begin
      Ack_o       <= '0;
      Valid_o     <= '0;
      Eng_Start_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sel_found) begin
            grant       <= sel_idx;
            ptr         <= sel_idx;
            Eng_Angle_o <= sel_angle;
            Ack_o       <= ONE_HOT0 << sel_idx;
            Eng_Start_o <= 1'b1;
            Busy_o      <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
`ifdef SINE_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= S_CLEAR;
        end
        // Completion is only accepted after done has been seen low, so a
        // done level left over from the previous job is never mistaken
        // for this job's result.
        S_CLEAR: begin
`ifdef SINE_ARB_TIMEOUT_EN
          if (tmo_hit) begin
            Result_o <= '0;
            Err_o    <= 1'b1;
            Valid_o  <= grant_oh;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (!Eng_Done_i) state <= S_BUSY;
          end
`else
          if (!Eng_Done_i) state <= S_BUSY;
`endif
        end
        S_BUSY: begin
`ifdef SINE_ARB_TIMEOUT_EN
          if (tmo_hit) begin
            Result_o <= '0;
            Err_o    <= 1'b1;
            Valid_o  <= grant_oh;
            state    <= S_RESP;
          end else if (Eng_Done_i) begin
            Result_o <= Eng_Sine_i;
            Err_o    <= 1'b0;
            Valid_o  <= grant_oh;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`else
          if (Eng_Done_i) begin
            Result_o <= Eng_Sine_i;
            Valid_o  <= grant_oh;
            state    <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          Busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          Busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_req_arbiter.sv
`timescale 1ns/1ps
module tb_sine_req_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  angles = '0;
  logic [NR-1:0]     Ack_o, Valid_o;
  logic [DW-1:0]     Result_o, Eng_Angle_o;
  logic              Err_o, Busy_o, Eng_Start_o;
  logic              eng_done;
  logic [DW-1:0]     eng_sine;

  sine_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(64)) dut (
    .Clk_i(clk), .Rst_ni(rst_n), .Req_i(req), .Angle_i(angles),
    .Ack_o(Ack_o), .Valid_o(Valid_o), .Result_o(Result_o), .Err_o(Err_o),
    .Busy_o(Busy_o), .Eng_Start_o(Eng_Start_o), .Eng_Angle_o(Eng_Angle_o),
    .Eng_Done_i(eng_done), .Eng_Sine_i(eng_sine)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: done drops 1 cycle after start, rises 17 cycles
  // after start, sine = angle ^ 16'hA5A5. stale_extra delays the drop.
  int   phase = 0, ecnt = 0, stale_extra = 0;
  logic never_done = 1'b0;
  logic fresh = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_done <= 1'b0; eng_sine <= '0; phase <= 0; ecnt <= 0; fresh <= 1'b0;
    end else if (Eng_Start_o) begin
      fresh <= 1'b0;
      if (stale_extra > 0) begin phase <= 1; ecnt <= stale_extra; end
      else begin eng_done <= 1'b0; phase <= 2; ecnt <= 16; end
    end else if (phase == 1) begin
      if (ecnt <= 1) begin eng_done <= 1'b0; phase <= 2; ecnt <= 16; end
      else ecnt <= ecnt - 1;
    end else if (phase == 2 && !never_done) begin
      if (ecnt <= 1) begin
        eng_done <= 1'b1; eng_sine <= Eng_Angle_o ^ 16'hA5A5;
        fresh <= 1'b1; phase <= 0;
      end else ecnt <= ecnt - 1;
    end
  end

  typedef struct { int idx; logic [DW-1:0] val; logic err; } exp_t;
  exp_t ack_q[$];
  exp_t res_q[$];
  int total = 0, bad = 0;
  int last_ack_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents Ack_o or Valid_o.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (Ack_o != '0) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 32'(Ack_o), 32'h0);
        else begin
          me = ack_q.pop_front();
          chk("ack_onehot", 32'(Ack_o), 32'(1) << me.idx);
          chk("eng_angle", 32'(Eng_Angle_o), 32'(me.val));
          chk("busy_at_ack", 32'(Busy_o), 32'h1);
        end
        last_ack_cyc = cyc;
      end
      if (Valid_o != '0) begin
        if (res_q.size() == 0) chk("unexpected_valid", 32'(Valid_o), 32'h0);
        else begin
          me = res_q.pop_front();
          chk("valid_onehot", 32'(Valid_o), 32'(1) << me.idx);
          chk("result", 32'(Result_o), 32'(me.val));
          chk("err", 32'(Err_o), 32'(me.err));
          if (me.err) chk("timeout_latency", 32'(cyc - last_ack_cyc), 32'd65);
          else        chk("fresh_done", 32'(fresh), 32'h1);
        end
      end
    end
  end

  task automatic push_job(input int k, input logic [DW-1:0] a, input bit with_res);
    exp_t e;
    angles[k*DW +: DW] = a;
    e.idx = k; e.val = a; e.err = 1'b0;
    ack_q.push_back(e);
    if (with_res) begin
      e.val = a ^ 16'hA5A5;
      res_q.push_back(e);
    end
  endtask

  task automatic wait_ack(input bit drop, output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (Ack_o != '0) begin
        n = i;
        if (drop) req = req & ~Ack_o;
        return;
      end
    end
    chk("ack_wait_expired", 32'h0, 32'h1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!Busy_o && res_q.size() == 0 && ack_q.size() == 0) return;
    end
    chk("idle_wait_expired", 32'h0, 32'h1);
  endtask

  task automatic check_outputs_zero();
    chk("rst_ack", 32'(Ack_o), 32'h0);
    chk("rst_valid", 32'(Valid_o), 32'h0);
    chk("rst_result", 32'(Result_o), 32'h0);
    chk("rst_err", 32'(Err_o), 32'h0);
    chk("rst_busy", 32'(Busy_o), 32'h0);
    chk("rst_start", 32'(Eng_Start_o), 32'h0);
    chk("rst_eng_angle", 32'(Eng_Angle_o), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check_outputs_zero();
    rst_n = 1'b1;
  endtask

  int n;
  initial begin
    do_reset();

    // 1: single request from requester 2
    @(negedge clk);
    push_job(2, 16'h1000, 1'b1);
    req[2] = 1'b1;
    wait_ack(1'b1, n);
    chk("single_ack_latency", 32'(n), 32'd1);
    wait_idle();

    // 2: all four together right after reset -> 0,1,2,3
    do_reset();
    @(negedge clk);
    for (int k = 0; k < NR; k++) push_job(k, DW'(k + 1), 1'b1);
    req = '1;
    for (int k = 0; k < NR; k++) wait_ack(1'b1, n);
    wait_idle();

    // 3: requesters 0 and 3 held high -> 0,3,0,3,0,3
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      push_job(0, 16'h0010, 1'b1);
      push_job(3, 16'h0300, 1'b1);
    end
    req = 4'b1001;
    for (int g = 0; g < 6; g++) wait_ack(1'b0, n);
    req = '0;
    wait_idle();

    // 4: stale done held past START
    stale_extra = 6;
    @(negedge clk);
    chk("stale_done_precondition", 32'(eng_done), 32'h1);
    push_job(1, 16'h00FF, 1'b1);
    req[1] = 1'b1;
    wait_ack(1'b1, n);
    wait_idle();
    stale_extra = 0;

    // 5: reset during BUSY, aborted job yields no Valid; pointer restarts
    @(negedge clk);
    push_job(2, 16'h0777, 1'b0);
    req[2] = 1'b1;
    wait_ack(1'b1, n);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero();
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    push_job(0, 16'h4000, 1'b1);
    push_job(3, 16'h0003, 1'b1);
    req = 4'b1001;
    wait_ack(1'b1, n);
    wait_ack(1'b1, n);
    wait_idle();

`ifdef SINE_ARB_TIMEOUT_EN
    // 6: engine never finishes -> timeout response, then normal service
    begin
      exp_t e;
      never_done = 1'b1;
      @(negedge clk);
      angles[1*DW +: DW] = 16'h1234;
      e.idx = 1; e.val = 16'h1234; e.err = 1'b0; ack_q.push_back(e);
      e.val = '0; e.err = 1'b1; res_q.push_back(e);
      req[1] = 1'b1;
      wait_ack(1'b1, n);
      wait_idle();
      never_done = 1'b0;
      @(negedge clk);
      push_job(2, 16'h0F0F, 1'b1);
      req[2] = 1'b1;
      wait_ack(1'b1, n);
      wait_idle();
    end
`endif

    repeat (5) @(negedge clk);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'h0);
    chk("res_queue_drained", 32'(res_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
